gost_ctr_gamma: RTL and testbench
=================================

Name: gost_ctr_gamma

Overview:
Counter-mode (gamma, "gammirovanie") sequencer that sits between the system data path and the 64-bit GOST 28147-89 encryption core. It loads a synchro-message (IV) and encrypts it once through the core to get the initial state S. For each data block it steps the GOST counters, has the core encrypt them into a 64-bit gamma, and outputs data XOR gamma over valid/ready handshakes. The key is loaded into the core elsewhere; this block drives only core_load, core_mode and core_pdata, and consumes core_done and core_cdata.

Parameters:
TIMEOUT, 40, cycles allowed from core_load to core_done before the block flags err and returns to IDLE.

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
iv_load  in  1  pulse: capture iv and (re)start synchronisation
iv  in  64  synchro-message
in_valid  in  1  plaintext/ciphertext block valid
in_ready  out  1  block accepted when in_valid && in_ready
in_data  in  64  input block
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  64  in_data XOR gamma
err  out  1  sticky core-timeout flag; cleared by rst or iv_load
core_load  out  1  one-cycle start pulse to the core
core_mode  out  1  tied 0 (encrypt); counter mode always encrypts
core_pdata  out  64  block to encrypt
core_done  in  1  core result-ready pulse; ignored unless in a WAIT state
core_cdata  in  64  core result; sampled only in the cycle core_done=1

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, err=0, core_load=0, core_pdata=0; N3=N4=0, gamma=0, timer=0, state IDLE.
- FSM states: IDLE, SYNC_WAIT, STEP, GEN_WAIT, HAVE_GAMMA, OUT.
- IDLE: waits for iv_load. iv_load in any state, including mid-operation: core_pdata<=iv, core_load=1 next cycle, err<=0, out_valid<=0 (pending output dropped), timer<=0, go to SYNC_WAIT. iv_load has priority over every other event in the same cycle.
- SYNC_WAIT: on core_done, N3<=core_cdata[31:0] and N4<=core_cdata[63:32], go to STEP.
- STEP (1 cycle): N3<=N3+C2 mod 2^32. N4<=N4+C1 mod (2^32-1), computed as a 33-bit sum s, result s[31:0]+s[32] (end-around carry); 0xFFFFFFFF is a legal stored value. core_pdata<={N4',N3'}, core_load=1, go to GEN_WAIT.
- GEN_WAIT: on core_done, gamma<=core_cdata, go to HAVE_GAMMA.
- HAVE_GAMMA: in_ready=1 (the only state where it is 1). On handshake: out_data<=in_data^gamma, out_valid<=1, go to OUT.
- OUT: hold out_valid and out_data stable. On out_valid&&out_ready: out_valid<=0, go to STEP. The next gamma is then computed from the current N3/N4.
- Timer: counts in SYNC_WAIT and GEN_WAIT. If it reaches TIMEOUT without core_done: err<=1, go to IDLE.
- core_done in IDLE, STEP, HAVE_GAMMA or OUT (the core free-runs and pulses periodically) is ignored.
- Latency: iv_load to in_ready is about 2×core latency + 3 cycles. Accept to out_valid is 1 cycle. Accept to next in_ready is out handshake + 1 + core latency.
- core_load is never asserted while a core operation is outstanding, except on iv_load restart; the new load resynchronises the core.

Decomposition:
- Package gost_pkg holds C1=32'h01010104, C2=32'h01010101, the FSM state enum typedef, and a function add_mod_2p32m1(a,b) for the end-around-carry add.
- One sub-module is natural: gost_ctr_step, a combinational N3/N4 increment that is reused by the MAC/feedback blocks.

Test Plan:
- Counter arithmetic: N4=0xFEFEFEFB -> 0xFFFFFFFF. N4=0xFFFFFFFF -> 0x01010104. N3=0xFFFFFFFF -> 0x01010100.
- Known-answer: the real core with a fixed key and iv=64'h0 encrypts 4 blocks; out_data matches a software GOST CTR model bit-exact. Encrypting the result again with the same iv returns the original plaintext.
- Backpressure: hold out_ready=0 for 50 cycles. out_valid and out_data stay stable, in_ready=0, and no core_load is issued during that time.
- Spurious core_done pulses in IDLE and HAVE_GAMMA leave N3, N4 and gamma unchanged.
- iv_load asserted in OUT with out_valid=1: out_valid goes to 0 next cycle, core_load pulses with core_pdata=new iv, and the block stream restarts from the new S.
- Core model withholds core_done: err=1 exactly TIMEOUT cycles after core_load, state returns to IDLE, and the next iv_load clears err.

Source files
------------

// File: rtl/gost_pkg.sv
// Shared GOST 28147-89 counter-mode constants, FSM state type and mod (2^32-1) adder.
package gost_pkg;

  localparam logic [31:0] C1 = 32'h01010104;
  localparam logic [31:0] C2 = 32'h01010101;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    STEP,
    GEN_WAIT,
    HAVE_GAMMA,
    OUT
  } state_t;

  // End-around carry: 0xFFFFFFFF stays representable, so this is not a plain mod-reduce.
  function automatic logic [31:0] add_mod_2p32m1(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[31:0] + {31'd0, s[32]};
  endfunction

endpackage

// File: rtl/gost_ctr_step.sv
// Combinational GOST counter increment: N3 += C2 mod 2^32, N4 += C1 mod (2^32-1).
// Zero latency, no flow control; shared with the MAC/feedback blocks.
module gost_ctr_step
  import gost_pkg::*;
(
  input  logic [31:0] n3,
  input  logic [31:0] n4,
  output logic [31:0] n3_next,
  output logic [31:0] n4_next
);

  assign n3_next = n3 + C2;
  assign n4_next = add_mod_2p32m1(n4, C1);

endmodule

// File: rtl/gost_ctr_gamma.sv
// Counter-mode (gamma) sequencer around a 64-bit GOST core: out_data = in_data ^ E(counters).
// Accept to out_valid is 1 cycle; out_valid holds under backpressure and no core work starts until it drains.
module gost_ctr_gamma
  import gost_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iv_load,
  input  logic [63:0] iv,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        err,
  output logic        core_load,
  output logic        core_mode,
  output logic [63:0] core_pdata,
  input  logic        core_done,
  input  logic [63:0] core_cdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic [31:0]   n3, n4, n3_step, n4_step;
  logic [63:0]   gamma;
  logic [TW-1:0] timer;
  logic          timed_out;

  assign core_mode = 1'b0;
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  gost_ctr_step u_step (
    .n3      (n3),
    .n4      (n4),
    .n3_next (n3_step),
    .n4_next (n4_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // iv_load wins over every other event; in_ready drops with it so no block is lost.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    if (iv_load) begin
      state_next = SYNC_WAIT;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        SYNC_WAIT: begin
          if (core_done)      state_next = STEP;
          else if (timed_out) state_next = IDLE;
        end
        STEP: state_next = GEN_WAIT;
        GEN_WAIT: begin
          if (core_done)      state_next = HAVE_GAMMA;
          else if (timed_out) state_next = IDLE;
        end
        HAVE_GAMMA: begin
          in_ready = 1'b1;
          if (in_valid) state_next = OUT;
        end
        OUT: begin
          if (out_ready) state_next = STEP;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n3         <= '0;
      n4         <= '0;
      gamma      <= '0;
      timer      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      err        <= 1'b0;
      core_load  <= 1'b0;
      core_pdata <= '0;
    end else begin
      core_load <= 1'b0;
      if (iv_load) begin
        core_pdata <= iv;
        core_load  <= 1'b1;
        err        <= 1'b0;
        out_valid  <= 1'b0;
        timer      <= '0;
      end else begin
        case (state)
          SYNC_WAIT: begin
            if (core_done) begin
              n3 <= core_cdata[31:0];
              n4 <= core_cdata[63:32];
            end else if (timed_out) begin
              err <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          STEP: begin
            n3         <= n3_step;
            n4         <= n4_step;
            core_pdata <= {n4_step, n3_step};
            core_load  <= 1'b1;
            timer      <= '0;
          end
          GEN_WAIT: begin
            if (core_done) begin
              gamma <= core_cdata;
            end else if (timed_out) begin
              err <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          HAVE_GAMMA: begin
            if (in_valid) begin
              out_data  <= in_data ^ gamma;
              out_valid <= 1'b1;
            end
          end
          OUT: begin
            if (out_ready) out_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gost_ctr_gamma.sv
// Directed bench for gost_ctr_gamma with a stand-in core E(x) = x ^ CORE_MASK (fixed latency).
module tb_gost_ctr_gamma;

  localparam int          TIMEOUT   = 40;
  localparam logic [63:0] CORE_MASK = 64'hFEFEFEFB_FFFFFFFF;
  localparam logic [63:0] NEW_IV    = 64'h00000001_00000002;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv_load;
  logic [63:0] iv;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        err;
  logic        core_load;
  logic        core_mode;
  logic [63:0] core_pdata;
  logic        core_done;
  logic [63:0] core_cdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gost_ctr_gamma #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .iv_load    (iv_load),
    .iv         (iv),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err),
    .core_load  (core_load),
    .core_mode  (core_mode),
    .core_pdata (core_pdata),
    .core_done  (core_done),
    .core_cdata (core_cdata)
  );

  // Core stand-in: answers each core_load after a few cycles unless withheld.
  int          lat        = 5;
  bit          withhold   = 1'b0;
  bit          spur       = 1'b0;
  bit          model_done = 1'b0;
  logic [63:0] model_cdata = '0;
  bit          busy       = 1'b0;
  int          cnt        = 0;
  logic [63:0] res        = '0;
  int          loads      = 0;
  logic [63:0] last_pdata = '0;

  assign core_done  = model_done | spur;
  assign core_cdata = spur ? 64'h5A5A_A5A5_1234_8765 : model_cdata;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (core_load) begin
      busy       = 1'b1;
      cnt        = lat;
      res        = core_pdata ^ CORE_MASK;
      loads      = loads + 1;
      last_pdata = core_pdata;
    end else if (busy) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        busy = 1'b0;
        if (!withhold) begin
          model_done  = 1'b1;
          model_cdata = res;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    check(tag, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Hand-derived stream for S = CORE_MASK (iv = 0): counter block and gamma per step.
  logic [63:0] exp_pdata [4];
  logic [63:0] exp_gamma [4];
  logic [63:0] pt        [4];
  logic [63:0] ct        [4];

  initial begin
    int          n;
    int          l0;
    bit          stable;
    logic [63:0] d0;

    exp_pdata[0] = 64'hFFFFFFFF_01010100;  exp_gamma[0] = 64'h01010104_FEFEFEFF;
    exp_pdata[1] = 64'h01010104_02020201;  exp_gamma[1] = 64'hFFFFFFFF_FDFDFDFE;
    exp_pdata[2] = 64'h02020208_03030302;  exp_gamma[2] = 64'hFCFCFCF3_FCFCFCFD;
    exp_pdata[3] = 64'h0303030C_04040403;  exp_gamma[3] = 64'hFDFDFDF7_FBFBFBFC;
    pt[0] = 64'h01234567_89ABCDEF;
    pt[1] = 64'h00000000_00000000;
    pt[2] = 64'hFFFFFFFF_FFFFFFFF;
    pt[3] = 64'hDEADBEEF_CAFEF00D;

    rst = 1'b1; iv_load = 1'b0; iv = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",   {63'd0, in_ready},  64'd0);
    check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_out_data",   out_data,           64'd0);
    check("rst_err",        {63'd0, err},       64'd0);
    check("rst_core_load",  {63'd0, core_load}, 64'd0);
    check("rst_core_pdata", core_pdata,         64'd0);
    check("core_mode",      {63'd0, core_mode}, 64'd0);
    rst = 1'b0;

    // Spurious done in IDLE must not disturb the later stream.
    spur = 1'b1; tick(); spur = 1'b0; tick();
    check("idle_no_load", {63'd0, core_load}, 64'd0);

    iv_load = 1'b1; iv = '0; tick(); iv_load = 1'b0;
    check("sync_load",  {63'd0, core_load}, 64'd1);
    check("sync_pdata", core_pdata,         64'd0);
    wait_rdy("rdy0");
    check("step0_pdata", last_pdata, exp_pdata[0]);

    spur = 1'b1; tick(); spur = 1'b0;
    check("hg_spur_rdy", {63'd0, in_ready}, 64'd1);

    send(pt[0]);
    ct[0] = pt[0] ^ exp_gamma[0];
    check("blk0_valid", {63'd0, out_valid}, 64'd1);
    check("blk0_data",  out_data,           ct[0]);

    // Backpressure: output frozen, nothing accepted, core left idle.
    l0 = loads; d0 = out_data; stable = 1'b1;
    repeat (50) begin
      tick();
      if (!out_valid || out_data !== d0 || in_ready) stable = 1'b0;
    end
    check("bp_stable", {63'd0, stable}, 64'd1);
    check("bp_loads",  64'(loads),      64'(l0));
    check("bp_data",   out_data,        ct[0]);

    out_ready = 1'b1; tick();
    check("blk0_drain", {63'd0, out_valid}, 64'd0);

    for (int i = 1; i < 4; i++) begin
      wait_rdy("rdy_n");
      check("step_pdata", last_pdata, exp_pdata[i]);
      send(pt[i]);
      ct[i] = pt[i] ^ exp_gamma[i];
      check("blk_data", out_data, ct[i]);
      tick();
      check("blk_drain", {63'd0, out_valid}, 64'd0);
    end

    // Same iv applied to the ciphertext recovers the plaintext.
    iv_load = 1'b1; iv = '0; tick(); iv_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rdy("rt_rdy");
      send(ct[i]);
      check("rt_data", out_data, pt[i]);
      tick();
    end

    // Restart while a result is still pending in OUT.
    wait_rdy("pre_restart_rdy");
    out_ready = 1'b0;
    send(64'h1111_2222_3333_4444);
    check("pend_valid", {63'd0, out_valid}, 64'd1);
    iv_load = 1'b1; iv = NEW_IV; tick(); iv_load = 1'b0;
    check("restart_drop",  {63'd0, out_valid}, 64'd0);
    check("restart_load",  {63'd0, core_load}, 64'd1);
    check("restart_pdata", core_pdata,         NEW_IV);
    out_ready = 1'b1;
    wait_rdy("restart_rdy");
    check("restart_step_pdata", last_pdata, 64'hFFFFFFFE_010100FE);
    send(pt[0]);
    check("restart_data", out_data, pt[0] ^ 64'h01010105_FEFEFF01);
    tick();

    // Core never answers: err rises TIMEOUT cycles after core_load.
    withhold = 1'b1;
    iv_load = 1'b1; iv = '0; tick(); iv_load = 1'b0;
    check("to_load", {63'd0, core_load}, 64'd1);
    n = 0;
    while (!err && n < 200) begin
      tick();
      n++;
    end
    check("to_cycles", 64'(n), 64'(TIMEOUT));
    check("to_in_ready", {63'd0, in_ready}, 64'd0);
    l0 = loads;
    repeat (10) tick();
    check("to_idle_loads", 64'(loads), 64'(l0));
    check("to_err_sticky", {63'd0, err}, 64'd1);

    withhold = 1'b0;
    iv_load = 1'b1; iv = '0; tick(); iv_load = 1'b0;
    check("to_err_clear", {63'd0, err}, 64'd0);
    wait_rdy("to_rdy");
    check("to_step_pdata", last_pdata, exp_pdata[0]);
    send(pt[3]);
    check("to_data", out_data, pt[3] ^ exp_gamma[0]);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
